tcp_tx_sched: RTL and testbench
===============================

Name: tcp_tx_sched

Overview:
- Sequencer and arbiter in front of the GMII/MII TCP segment sender in the webcamera Ethernet path.
- Arbitrates three requesters: control segments (SYN/FIN/RST/pure ACK), retransmissions and new payload data.
- Latches and holds the chosen requester's header fields, pulses the sender's Task input, then tracks the sender's Sender_valid until the frame completes.
- Owns the send-next sequence number (snd_nxt) and enforces an inter-frame gap.

Parameters:
- ISN, 32'h0000_1000, initial snd_nxt after reset.
- MAX_LEN, 1024, maximum payload bytes per segment; must be a multiple of 4.
- IFG_CYCLES, 24, idle clocks after frame completion before the next Task pulse (nibble clocks).
- TIMEOUT_CYCLES, 16'd8000, maximum clocks to wait for frame completion.
- MAX_SKIP, 4, starvation-guard threshold (used only with the optional feature).

Ports:
- clk  in  1  sender clock; this block uses the posedge.
- rst_n  in  1  asynchronous active-low reset.
- src_ip, des_ip  in  32  static connection config.
- src_port, des_port  in  16  static connection config.
- tcp_window  in  16  static connection config.
- ack_num  in  32  current receive-side acknowledge number, sampled in LOAD.
- ctl_req  in  1  control-segment request.
- ctl_flags  in  6  {URG,ACK,PSH,RST,SYN,FIN} for the control segment.
- ctl_gnt, ctl_done  out  1  grant pulse; completion pulse.
- rtx_req  in  1  retransmission request.
- rtx_seq  in  32  sequence number of the retransmitted segment.
- rtx_len  in  16  payload length of the retransmitted segment.
- rtx_gnt, rtx_done  out  1  grant pulse; completion pulse.
- dat_req  in  1  new-data request.
- dat_len  in  16  new-data payload bytes.
- dat_gnt, dat_done  out  1  grant pulse; completion pulse.
- task  out  1  start pulse to the sender.
- data_len  out  16  payload length field to the sender.
- seq_num, ack_num_o  out  32  sequence and acknowledge fields to the sender.
- head_len  out  4  TCP header length to the sender.
- tcp_flags  out  6  flag field to the sender.
- sender_valid  in  1  sender idle/done indication.
- busy  out  1  high in every state except IDLE.
- tx_err  out  1  one-cycle pulse on completion timeout.
- frame_cnt  out  16  count of completed frames.

Behaviour:
- Reset (async, any state): FSM=IDLE; snd_nxt=ISN; all gnt/done/task/tx_err low; data_len=0; seq_num=0; ack_num_o=0; tcp_flags=0; frame_cnt=0; head_len constant 4'd5.
- FSM transitions:
  - IDLE: go to LOAD when any request is pending and sender_valid=1.
  - LOAD: 1 cycle; latch the winner's fields; assert that requester's gnt for this cycle.
  - KICK: task=1 for exactly 2 cycles.
  - WAIT_LOW: wait for sender_valid=0.
  - WAIT_HIGH: wait for sender_valid=1.
  - GAP: count IFG_CYCLES, then return to IDLE.
- Priority: ctl > rtx > dat. Arbitration is evaluated only in IDLE. A request must be held until its gnt; gnt consumes it.
- Field selection:
  - ctl: data_len=0, seq=snd_nxt, flags=ctl_flags.
  - rtx: seq=rtx_seq, flags=ACK|PSH.
  - dat: seq=snd_nxt, flags=ACK|PSH.
- Length rule for rtx/dat: len' = min(len, MAX_LEN) with bits [1:0] forced to 0. If len' is 0, the segment is sent as a pure ACK (flags=ACK, data_len=0).
- Sequence update: on the WAIT_HIGH→GAP transition, snd_nxt += len' + SYN + FIN for ctl/dat segments (32-bit wrap). Retransmissions never change snd_nxt.
- Completion: the matching *_done pulses for 1 cycle on the WAIT_HIGH exit; frame_cnt increments and wraps at 16'hFFFF.
- Timeout: one counter spans WAIT_LOW+WAIT_HIGH. On reaching TIMEOUT_CYCLES: tx_err and *_done pulse together, snd_nxt is not advanced, FSM goes to GAP.
- Output timing: latency from gnt to the first task cycle is 1 clock. The sender-side outputs are stable from LOAD until IDLE is re-entered.
- Clocking: sender_valid comes from the sender's negedge flop in the same clock domain; it is sampled directly with no synchroniser.
- Requests arriving during busy wait in place; simultaneous requests are resolved by priority at the next IDLE.

Optional Feature:
- TCP_TX_STARVE_GUARD_EN defined: a skip counter increments each time dat_req is pending and ctl or rtx wins.
  - When the counter reaches MAX_SKIP, dat wins the next arbitration.
  - The counter clears on any dat grant or when dat_req is low.
- Not defined: strict fixed priority; dat can starve.

Decomposition:
- Shared package tcp_tx_pkg:
  - FSM state enum.
  - Flag bit indices and flag constants FLG_ACK_PSH, FLG_ACK.
  - Requester ID enum {REQ_CTL, REQ_RTX, REQ_DAT}.
  - HEAD_LEN_TCP=4'd5.
- One sub-module, tcp_tx_arb: combinational priority select plus the starvation-guard counter; outputs a one-hot winner.

Test Plan:
- ctl_req with flags SYN (6'b000010), ISN=0x1000, sender model returns sender_valid high 100 clocks after task:
  - ctl_gnt, then task high 2 cycles, seq_num=0x1000, data_len=0.
  - ctl_done; snd_nxt becomes 0x1001; next task no earlier than 24 clocks later.
- ctl, rtx and dat raised in the same cycle: grant order ctl, rtx, dat; three done pulses; frame_cnt=3.
- dat_len=1030, MAX_LEN=1024 → data_len=1024. Next dat_len=7 → data_len=4. snd_nxt advances by 1028 total.
- rtx_seq=0x2000, rtx_len=64: seq_num=0x2000, tcp_flags=ACK|PSH, snd_nxt unchanged.
- Sender never raises sender_valid: tx_err and dat_done pulse together at TIMEOUT_CYCLES; snd_nxt unchanged; FSM returns to IDLE after the gap.
- rst_n asserted mid-WAIT_HIGH: task/gnt/done go low immediately, snd_nxt=ISN. With TCP_TX_STARVE_GUARD_EN, continuous ctl_req plus dat_req grants dat on the 5th arbitration.

Source files
------------

// File: rtl/tcp_tx_pkg.sv
// Shared constants and helpers for the TCP transmit scheduler.
// Optional starvation guard is enabled with TCP_TX_STARVE_GUARD_EN.
package tcp_tx_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LOAD      = 3'd1;
   localparam logic [2:0] ST_KICK      = 3'd2;
   localparam logic [2:0] ST_WAIT_LOW  = 3'd3;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
   localparam logic [2:0] ST_GAP       = 3'd5;

   // Flag field layout {URG,ACK,PSH,RST,SYN,FIN}
   localparam int unsigned FLG_FIN_IDX = 0;
   localparam int unsigned FLG_SYN_IDX = 1;
   localparam logic [5:0]  FLG_ACK     = 6'b010000;
   localparam logic [5:0]  FLG_ACK_PSH = 6'b011000;

   typedef enum logic [1:0] {
      REQ_CTL = 2'd0,
      REQ_RTX = 2'd1,
      REQ_DAT = 2'd2
   } req_id_e;

   localparam logic [3:0] HEAD_LEN_TCP = 4'd5;

   // Cap a payload length and round down to a 4-byte multiple
   function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] max_len);
      logic [15:0] m;
      m = (len > max_len) ? max_len : len;
      return {m[15:2], 2'b00};
   endfunction

endpackage

// File: rtl/tcp_tx_arb.sv
// Fixed-priority requester select (ctl > rtx > dat) with one-hot winner.
// TCP_TX_STARVE_GUARD_EN adds a skip counter that forces a dat win.
module tcp_tx_arb
   import tcp_tx_pkg::*;
#(
   parameter int unsigned MAX_SKIP = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ctl_req,
   input  logic       rtx_req,
   input  logic       dat_req,
   input  logic       take,
   output logic [2:0] win_c
);

   logic starve_c;

`ifdef TCP_TX_STARVE_GUARD_EN
   localparam int unsigned SKIP_W = $clog2(MAX_SKIP + 1);

   logic [SKIP_W-1:0] skip_q, skip_d;

   assign starve_c = dat_req && (skip_q == SKIP_W'(MAX_SKIP));

   // Count arbitrations lost by a pending dat request
   always_comb begin
      skip_d = skip_q;
      if (!dat_req || (take && win_c[REQ_DAT])) begin
         skip_d = '0;
      end else if (take && (skip_q != SKIP_W'(MAX_SKIP))) begin
         skip_d = skip_q + SKIP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skip_q <= '0;
      end else begin
         skip_q <= skip_d;
      end
   end
`else
   logic unused_c;
   assign unused_c = &{1'b0, clk, rst_n, take, 32'(MAX_SKIP)};
   assign starve_c = 1'b0;
`endif

   always_comb begin
      win_c = 3'b000;
      if (starve_c) begin
         win_c[REQ_DAT] = 1'b1;
      end else if (ctl_req) begin
         win_c[REQ_CTL] = 1'b1;
      end else if (rtx_req) begin
         win_c[REQ_RTX] = 1'b1;
      end else if (dat_req) begin
         win_c[REQ_DAT] = 1'b1;
      end
   end

endmodule

// File: rtl/tcp_tx_sched.sv
// Arbitrates ctl/rtx/dat segments, drives the TCP sender and owns snd_nxt.
// Build with TCP_TX_STARVE_GUARD_EN to bound dat starvation.
module tcp_tx_sched
   import tcp_tx_pkg::*;
#(
   parameter logic [31:0] ISN            = 32'h0000_1000,
   parameter int unsigned MAX_LEN        = 1024,
   parameter int unsigned IFG_CYCLES     = 24,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd8000,
   parameter int unsigned MAX_SKIP       = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] src_ip,
   input  logic [31:0] des_ip,
   input  logic [15:0] src_port,
   input  logic [15:0] des_port,
   input  logic [15:0] tcp_window,
   input  logic [31:0] ack_num,
   input  logic        ctl_req,
   input  logic [5:0]  ctl_flags,
   output logic        ctl_gnt,
   output logic        ctl_done,
   input  logic        rtx_req,
   input  logic [31:0] rtx_seq,
   input  logic [15:0] rtx_len,
   output logic        rtx_gnt,
   output logic        rtx_done,
   input  logic        dat_req,
   input  logic [15:0] dat_len,
   output logic        dat_gnt,
   output logic        dat_done,
   output logic        task_o,       // "task" is a reserved word
   output logic [15:0] data_len,
   output logic [31:0] seq_num,
   output logic [31:0] ack_num_o,
   output logic [3:0]  head_len,
   output logic [5:0]  tcp_flags,
   input  logic        sender_valid,
   output logic        busy,
   output logic        tx_err,
   output logic [15:0] frame_cnt
);

   localparam int unsigned GAP_W = $clog2(IFG_CYCLES + 1);

   logic [2:0]       state_q, state_d;
   logic [2:0]       sel_q, sel_d;
   logic [2:0]       gnt_q, gnt_d;
   logic [2:0]       done_q, done_d;
   logic             task_q, task_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             kick_q, kick_d;
   logic [15:0]      data_len_q, data_len_d;
   logic [31:0]      seq_q, seq_d;
   logic [31:0]      ack_q, ack_d;
   logic [5:0]       flags_q, flags_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;
   logic [31:0]      snd_nxt_q, snd_nxt_d;
   logic [15:0]      tmo_q, tmo_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [2:0]       win_c;
   logic             take_c;
   logic [15:0]      len_c;

   // Connection config goes straight to the sender; not used here
   logic unused_c;
   assign unused_c = &{1'b0, src_ip, des_ip, src_port, des_port, tcp_window};

   assign take_c = (state_q == ST_IDLE) && (ctl_req || rtx_req || dat_req) && sender_valid;

   tcp_tx_arb #(.MAX_SKIP(MAX_SKIP)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .ctl_req (ctl_req),
      .rtx_req (rtx_req),
      .dat_req (dat_req),
      .take    (take_c),
      .win_c   (win_c)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      gnt_d       = 3'b000;
      done_d      = 3'b000;
      err_d       = 1'b0;
      kick_d      = kick_q;
      data_len_d  = data_len_q;
      seq_d       = seq_q;
      ack_d       = ack_q;
      flags_d     = flags_q;
      frame_cnt_d = frame_cnt_q;
      snd_nxt_d   = snd_nxt_q;
      tmo_d       = tmo_q;
      gap_d       = gap_q;
      len_c       = win_c[REQ_RTX] ? clamp_len(rtx_len, 16'(MAX_LEN))
                                   : clamp_len(dat_len, 16'(MAX_LEN));

      case (state_q)
         ST_IDLE: begin
            if (take_c) begin
               state_d = ST_LOAD;
               sel_d   = win_c;
               gnt_d   = win_c;
               ack_d   = ack_num;
               if (win_c[REQ_CTL]) begin
                  data_len_d = 16'd0;
                  seq_d      = snd_nxt_q;
                  flags_d    = ctl_flags;
               end else begin
                  data_len_d = len_c;
                  seq_d      = win_c[REQ_RTX] ? rtx_seq : snd_nxt_q;
                  flags_d    = (len_c == 16'd0) ? FLG_ACK : FLG_ACK_PSH;
               end
            end
         end
         ST_LOAD: begin
            state_d = ST_KICK;
            kick_d  = 1'b0;
         end
         ST_KICK: begin
            if (kick_q) begin
               state_d = ST_WAIT_LOW;
               tmo_d   = 16'd0;
            end else begin
               kick_d = 1'b1;
            end
         end
         ST_WAIT_LOW, ST_WAIT_HIGH: begin
            tmo_d = tmo_q + 16'd1;
            if ((state_q == ST_WAIT_HIGH) && sender_valid) begin
               state_d     = ST_GAP;
               gap_d       = '0;
               done_d      = sel_q;
               frame_cnt_d = frame_cnt_q + 16'd1;
               // Retransmissions resend old sequence space
               if (!sel_q[REQ_RTX]) begin
                  snd_nxt_d = snd_nxt_q + 32'(data_len_q)
                              + 32'(flags_q[FLG_SYN_IDX]) + 32'(flags_q[FLG_FIN_IDX]);
               end
            end else if (tmo_q == (TIMEOUT_CYCLES - 16'd1)) begin
               state_d = ST_GAP;
               gap_d   = '0;
               done_d  = sel_q;
               err_d   = 1'b1;
            end else if ((state_q == ST_WAIT_LOW) && !sender_valid) begin
               state_d = ST_WAIT_HIGH;
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_W'(IFG_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      task_d = (state_d == ST_KICK);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sel_q       <= 3'b000;
         gnt_q       <= 3'b000;
         done_q      <= 3'b000;
         task_q      <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
         kick_q      <= 1'b0;
         data_len_q  <= '0;
         seq_q       <= '0;
         ack_q       <= '0;
         flags_q     <= '0;
         frame_cnt_q <= '0;
         snd_nxt_q   <= ISN;
         tmo_q       <= '0;
         gap_q       <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         task_q      <= task_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         kick_q      <= kick_d;
         data_len_q  <= data_len_d;
         seq_q       <= seq_d;
         ack_q       <= ack_d;
         flags_q     <= flags_d;
         frame_cnt_q <= frame_cnt_d;
         snd_nxt_q   <= snd_nxt_d;
         tmo_q       <= tmo_d;
         gap_q       <= gap_d;
      end
   end

   assign ctl_gnt   = gnt_q[REQ_CTL];
   assign rtx_gnt   = gnt_q[REQ_RTX];
   assign dat_gnt   = gnt_q[REQ_DAT];
   assign ctl_done  = done_q[REQ_CTL];
   assign rtx_done  = done_q[REQ_RTX];
   assign dat_done  = done_q[REQ_DAT];
   assign task_o    = task_q;
   assign data_len  = data_len_q;
   assign seq_num   = seq_q;
   assign ack_num_o = ack_q;
   assign head_len  = HEAD_LEN_TCP;
   assign tcp_flags = flags_q;
   assign busy      = busy_q;
   assign tx_err    = err_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tcp_tx_sched.sv
// Directed plus randomized bench for tcp_tx_sched with a behavioural sender
// and a segment-level reference model of snd_nxt and the header fields.
`timescale 1ns/1ps
module tb_tcp_tx_sched;

   localparam logic [31:0] ISN     = 32'h0000_1000;
   localparam int          MAX_LEN = 1024;
   localparam int          IFG     = 24;
   localparam int          TMO     = 8000;
   localparam int          DLY     = 100;
   localparam int          K_CTL   = 0;
   localparam int          K_RTX   = 1;
   localparam int          K_DAT   = 2;
   localparam logic [5:0]  F_ACK   = 6'b010000;
   localparam logic [5:0]  F_PSH   = 6'b001000;
   localparam logic [5:0]  F_RST   = 6'b000100;
   localparam logic [5:0]  F_SYN   = 6'b000010;
   localparam logic [5:0]  F_FIN   = 6'b000001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ack_num = '0;
   logic        ctl_req = 1'b0, rtx_req = 1'b0, dat_req = 1'b0;
   logic [5:0]  ctl_flags = '0;
   logic [31:0] rtx_seq = '0;
   logic [15:0] rtx_len = '0, dat_len = '0;
   logic        sender_valid = 1'b1;
   logic        ctl_gnt, ctl_done, rtx_gnt, rtx_done, dat_gnt, dat_done;
   logic        task_o, busy, tx_err;
   logic [15:0] data_len, frame_cnt;
   logic [31:0] seq_num, ack_num_o;
   logic [3:0]  head_len;
   logic [5:0]  tcp_flags;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   bit          hang = 1'b0;
   int          sv_cnt = 0;
   logic [31:0] snd_nxt_m = ISN;
   int          frames_m = 0;
   int          last_done_cyc = -1000;

   tcp_tx_sched dut (
      .clk(clk), .rst_n(rst_n),
      .src_ip(32'hC0A8_0001), .des_ip(32'hC0A8_0002),
      .src_port(16'd8080), .des_port(16'd5000), .tcp_window(16'd4096),
      .ack_num(ack_num),
      .ctl_req(ctl_req), .ctl_flags(ctl_flags), .ctl_gnt(ctl_gnt), .ctl_done(ctl_done),
      .rtx_req(rtx_req), .rtx_seq(rtx_seq), .rtx_len(rtx_len), .rtx_gnt(rtx_gnt), .rtx_done(rtx_done),
      .dat_req(dat_req), .dat_len(dat_len), .dat_gnt(dat_gnt), .dat_done(dat_done),
      .task_o(task_o), .data_len(data_len), .seq_num(seq_num), .ack_num_o(ack_num_o),
      .head_len(head_len), .tcp_flags(tcp_flags), .sender_valid(sender_valid),
      .busy(busy), .tx_err(tx_err), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Sender: drops valid on task, raises it DLY clocks later unless hung
   always @(negedge clk) begin
      if (!rst_n) begin
         sender_valid = 1'b1;
         sv_cnt = 0;
      end else if (task_o) begin
         sender_valid = 1'b0;
         sv_cnt = DLY;
      end else if (!sender_valid && !hang) begin
         if (sv_cnt <= 1) sender_valid = 1'b1;
         else sv_cnt = sv_cnt - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bound(input string tag, input int n, input int lim);
      checks++;
      assert (n < lim) else begin
         errors++;
         $error("FAIL %s waited=%0d limit=%0d", tag, n, lim);
      end
   endtask

   function automatic logic [15:0] clampm(input int len);
      int m;
      m = (len > MAX_LEN) ? MAX_LEN : len;
      return 16'((m / 4) * 4);
   endfunction

   // One full segment: expected fields from the model, then handshake checks
   task automatic run_frame(input int kind, input bit drop);
      logic [2:0]  oh;
      logic [15:0] e_len;
      logic [31:0] e_seq, e_ack;
      logic [5:0]  e_flg;
      int n;
      oh = 3'b001 << kind;
      e_ack = ack_num;
      case (kind)
         K_CTL: begin e_len = 16'd0; e_seq = snd_nxt_m; e_flg = ctl_flags; end
         K_RTX: begin
            e_len = clampm(int'(rtx_len)); e_seq = rtx_seq;
            e_flg = (e_len == 16'd0) ? F_ACK : (F_ACK | F_PSH);
         end
         default: begin
            e_len = clampm(int'(dat_len)); e_seq = snd_nxt_m;
            e_flg = (e_len == 16'd0) ? F_ACK : (F_ACK | F_PSH);
         end
      endcase
      n = 0;
      while (!(ctl_gnt | rtx_gnt | dat_gnt) && n < 400) begin @(negedge clk); n++; end
      chk_bound("gnt_wait", n, 400);
      chk("gnt", 32'({dat_gnt, rtx_gnt, ctl_gnt}), 32'(oh));
      chk("data_len", 32'(data_len), 32'(e_len));
      chk("seq_num", seq_num, e_seq);
      chk("tcp_flags", 32'(tcp_flags), 32'(e_flg));
      chk("ack_num_o", ack_num_o, e_ack);
      chk("head_len", 32'(head_len), 32'd5);
      if (drop) begin
         case (kind)
            K_CTL: ctl_req = 1'b0;
            K_RTX: rtx_req = 1'b0;
            default: dat_req = 1'b0;
         endcase
      end
      @(negedge clk);
      chk("task_first", 32'(task_o), 32'd1);
      chk("ifg_ok", 32'((cyc - last_done_cyc) >= IFG), 32'd1);
      @(negedge clk);
      chk("task_second", 32'(task_o), 32'd1);
      @(negedge clk);
      chk("task_end", 32'(task_o), 32'd0);
      n = 0;
      while (!(ctl_done | rtx_done | dat_done) && n < 400) begin @(negedge clk); n++; end
      chk_bound("done_wait", n, 400);
      chk("done", 32'({dat_done, rtx_done, ctl_done}), 32'(oh));
      chk("tx_err_idle", 32'(tx_err), 32'd0);
      last_done_cyc = cyc;
      if (kind != K_RTX) snd_nxt_m = snd_nxt_m + 32'(e_len) + 32'(e_flg[1]) + 32'(e_flg[0]);
      frames_m++;
      chk("frame_cnt", 32'(frame_cnt), 32'(frames_m));
      @(negedge clk);
      chk("done_pulse", 32'({dat_done, rtx_done, ctl_done}), 32'd0);
   endtask

   initial begin
      int n, t0, k;
      logic [5:0] ctl_tab [5];
      ctl_tab[0] = F_SYN; ctl_tab[1] = F_FIN | F_ACK; ctl_tab[2] = F_ACK;
      ctl_tab[3] = F_RST | F_ACK; ctl_tab[4] = F_SYN | F_ACK;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_task", 32'(task_o), 32'd0);
      chk("rst_seq", seq_num, 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_head_len", 32'(head_len), 32'd5);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // SYN from ISN
      ack_num = 32'h1111_2222; ctl_flags = F_SYN; ctl_req = 1'b1;
      run_frame(K_CTL, 1'b1);

      // Simultaneous requests resolve ctl, rtx, dat
      ctl_flags = F_ACK; rtx_seq = 32'h0000_0800; rtx_len = 16'd32; dat_len = 16'd100;
      ctl_req = 1'b1; rtx_req = 1'b1; dat_req = 1'b1;
      run_frame(K_CTL, 1'b1);
      run_frame(K_RTX, 1'b1);
      run_frame(K_DAT, 1'b1);

      // Length clamp and round-down
      dat_len = 16'd1030; dat_req = 1'b1; run_frame(K_DAT, 1'b1);
      dat_len = 16'd7;    dat_req = 1'b1; run_frame(K_DAT, 1'b1);
      dat_len = 16'd3;    dat_req = 1'b1; run_frame(K_DAT, 1'b1);

      // Retransmission leaves snd_nxt alone
      rtx_seq = 32'h0000_2000; rtx_len = 16'd64; rtx_req = 1'b1; run_frame(K_RTX, 1'b1);
      ctl_flags = F_ACK; ctl_req = 1'b1; run_frame(K_CTL, 1'b1);

      // Randomized segments
      for (int i = 0; i < 8; i++) begin
         k = int'($urandom_range(0, 2));
         ack_num = $urandom;
         case (k)
            K_CTL: begin ctl_flags = ctl_tab[$urandom_range(0, 4)]; ctl_req = 1'b1; end
            K_RTX: begin rtx_seq = $urandom; rtx_len = 16'($urandom_range(0, 1500)); rtx_req = 1'b1; end
            default: begin dat_len = 16'($urandom_range(0, 1500)); dat_req = 1'b1; end
         endcase
         run_frame(k, 1'b1);
      end

      // Completion timeout
      hang = 1'b1; dat_len = 16'd200; dat_req = 1'b1;
      n = 0;
      while (!dat_gnt && n < 400) begin @(negedge clk); n++; end
      chk_bound("tmo_gnt_wait", n, 400);
      dat_req = 1'b0;
      @(negedge clk);
      t0 = cyc;
      n = 0;
      while (!(ctl_done | rtx_done | dat_done) && n < TMO + 100) begin @(negedge clk); n++; end
      chk_bound("tmo_done_wait", n, TMO + 100);
      chk("tmo_err", 32'(tx_err), 32'd1);
      chk("tmo_done", 32'({dat_done, rtx_done, ctl_done}), 32'b100);
      chk("tmo_time", 32'(((cyc - t0) >= TMO) && ((cyc - t0) <= TMO + 4)), 32'd1);
      last_done_cyc = cyc;
      @(negedge clk);
      chk("tmo_err_pulse", 32'(tx_err), 32'd0);
      n = 0;
      while (busy && n < IFG + 10) begin @(negedge clk); n++; end
      chk_bound("tmo_idle_wait", n, IFG + 10);
      hang = 1'b0;
      dat_len = 16'd16; dat_req = 1'b1; run_frame(K_DAT, 1'b1);

      // Starvation behaviour under continuous ctl
      ctl_flags = F_ACK; ctl_req = 1'b1; dat_len = 16'd40; dat_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
`ifdef TCP_TX_STARVE_GUARD_EN
         if (i == 4) run_frame(K_DAT, 1'b1);
         else run_frame(K_CTL, 1'b0);
`else
         run_frame(K_CTL, 1'b0);
`endif
      end
      ctl_req = 1'b0; dat_req = 1'b0;

      // Async reset mid-WAIT_HIGH
      dat_len = 16'd64; dat_req = 1'b1;
      n = 0;
      while (!dat_gnt && n < 400) begin @(negedge clk); n++; end
      chk_bound("rst_gnt_wait", n, 400);
      dat_req = 1'b0;
      repeat (50) @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_task", 32'(task_o), 32'd0);
      chk("arst_gnt_done", 32'({ctl_gnt, rtx_gnt, dat_gnt, ctl_done, rtx_done, dat_done}), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_data_len", 32'(data_len), 32'd0);
      chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      snd_nxt_m = ISN; frames_m = 0;
      @(negedge clk);
      ctl_flags = F_SYN; ctl_req = 1'b1; run_frame(K_CTL, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
